// File: rtl/vram_dp_clear.sv
// Dual-port word memory with one-cycle registered reads and a background fill
// sweep that writes a latched value to every word, one word per clock.
module vram_dp_clear #(
   parameter int DATA_W   = 8,
   parameter int DEPTH    = 7200,
   parameter int ADDR_W   = 13,
   parameter int RDW_MODE = 0
) (
   input  logic              clock,
   input  logic              reset_n,
   input  logic [ADDR_W-1:0] address_a,
   input  logic [DATA_W-1:0] in_a,
   input  logic              write_a,
   output logic [DATA_W-1:0] out_a,
   input  logic [ADDR_W-1:0] address_b,
   input  logic [DATA_W-1:0] in_b,
   input  logic              write_b,
   output logic [DATA_W-1:0] out_b,
   input  logic              clear,
   input  logic [DATA_W-1:0] fill,
   output logic              busy,
   output logic              clear_done
);

   typedef enum logic [1:0] {IDLE, SWEEP, DONE} state_t;

   localparam logic [ADDR_W:0]   LP_DEPTH = (ADDR_W+1)'(DEPTH);
   localparam logic [ADDR_W-1:0] LP_LAST  = ADDR_W'(DEPTH - 1);

   state_t              r_state;
   state_t              w_state_nxt;
   logic [ADDR_W-1:0]   r_cnt;
   logic [DATA_W-1:0]   r_fill;
   logic [DATA_W-1:0]   r_out_a;
   logic [DATA_W-1:0]   r_out_b;
   logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

   logic                w_busy;
   logic                w_sweep;
   logic                w_a_in;
   logic                w_b_in;
   logic                w_a_wr;
   logic                w_b_wr;
   logic [DATA_W-1:0]   w_rd_a;
   logic [DATA_W-1:0]   w_rd_b;

   assign w_busy  = (r_state != IDLE);
   assign w_sweep = (r_state == SWEEP);
   assign w_a_in  = ({1'b0, address_a} < LP_DEPTH);
   assign w_b_in  = ({1'b0, address_b} < LP_DEPTH);

   // Port B yields to port A on a shared address and to the sweep on the
   // word currently being filled; port A is shut out for the whole sweep.
   assign w_a_wr = write_a && !w_busy && w_a_in;
   assign w_b_wr = write_b && w_b_in
                   && !(w_sweep && (address_b == r_cnt))
                   && !(w_a_wr && (address_a == address_b));

   assign w_rd_a = w_a_in ? r_mem[address_a] : '0;
   assign w_rd_b = w_b_in ? r_mem[address_b] : '0;

   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         IDLE:    if (clear) w_state_nxt = SWEEP;
         SWEEP:   if (r_cnt == LP_LAST) w_state_nxt = DONE;
         DONE:    w_state_nxt = IDLE;
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) r_state <= IDLE;
      else          r_state <= w_state_nxt;
   end

   // Counter parks on the last word; the next accepted clear rezeroes it.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_cnt  <= '0;
         r_fill <= '0;
      end else if ((r_state == IDLE) && clear) begin
         r_cnt  <= '0;
         r_fill <= fill;
      end else if (w_sweep && (r_cnt != LP_LAST)) begin
         r_cnt  <= r_cnt + ADDR_W'(1);
      end
   end

   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_out_a <= '0;
         r_out_b <= '0;
      end else begin
         if (!w_busy)
            r_out_a <= (write_a && w_a_in && (RDW_MODE == 0)) ? in_a : w_rd_a;
         r_out_b <= (write_b && w_b_in && (RDW_MODE == 0)) ? in_b : w_rd_b;
      end
   end

   always_ff @(posedge clock) begin
      if (w_b_wr)  r_mem[address_b] <= in_b;
      if (w_a_wr)  r_mem[address_a] <= in_a;
      if (w_sweep) r_mem[r_cnt]     <= r_fill;
   end

   assign out_a      = r_out_a;
   assign out_b      = r_out_b;
   assign busy       = w_busy;
   assign clear_done = (r_state == DONE);

endmodule

// File: tb/tb_vram_dp_clear.sv
// Bench for vram_dp_clear: cycle model of memory and sweep timing checked every
// cycle, plus directed vectors with literal expectations.
module tb_vram_dp_clear;
   localparam int DW = 8, DEPTH = 7200, AW = 13;

   logic          clock = 0, reset_n = 0;
   logic [AW-1:0] address_a = 0, address_b = 0;
   logic [DW-1:0] in_a = 0, in_b = 0, fill = 0;
   logic          write_a = 0, write_b = 0, clear = 0;
   wire  [DW-1:0] out_a, out_b;
   wire           busy, clear_done;

   logic [AW-1:0] address_a1 = 0, address_b1 = 0;
   logic [DW-1:0] in_a1 = 0, in_b1 = 0, fill1 = 0;
   logic          write_a1 = 0, write_b1 = 0, clear1 = 0;
   wire  [DW-1:0] out_a1, out_b1;
   wire           busy1, clear_done1;

   int checks = 0, errors = 0;

   vram_dp_clear #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RDW_MODE(0)) u_dut (
      .clock(clock), .reset_n(reset_n),
      .address_a(address_a), .in_a(in_a), .write_a(write_a), .out_a(out_a),
      .address_b(address_b), .in_b(in_b), .write_b(write_b), .out_b(out_b),
      .clear(clear), .fill(fill), .busy(busy), .clear_done(clear_done));

   vram_dp_clear #(.DATA_W(DW), .DEPTH(DEPTH), .ADDR_W(AW), .RDW_MODE(1)) u_dut1 (
      .clock(clock), .reset_n(reset_n),
      .address_a(address_a1), .in_a(in_a1), .write_a(write_a1), .out_a(out_a1),
      .address_b(address_b1), .in_b(in_b1), .write_b(write_b1), .out_b(out_b1),
      .clear(clear1), .fill(fill1), .busy(busy1), .clear_done(clear_done1));

   always #5 clock = ~clock;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   // Model: m_pos = cycles since the clear was accepted (-1 when idle);
   // positions 0..DEPTH-1 fill word m_pos, position DEPTH is the done cycle.
   int          m_pos = -1;
   logic [7:0]  m_fill = 0;
   logic [7:0]  m_mem [DEPTH];
   bit          m_known [DEPTH];
   logic [7:0]  e_a = 0, e_b = 0;
   bit          ka = 1, kb = 1;
   bit          mb_busy, mb_sweep, mb_aok, mb_bok, mb_oak, mb_obk;
   logic [7:0]  mb_oa, mb_ob;

   always @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         m_pos = -1; m_fill = 0; e_a = 0; e_b = 0; ka = 1; kb = 1;
      end else begin
         mb_busy  = (m_pos >= 0);
         mb_sweep = (m_pos >= 0) && (m_pos < DEPTH);
         mb_aok   = (address_a < DEPTH);
         mb_bok   = (address_b < DEPTH);
         mb_oa    = mb_aok ? m_mem[address_a] : 8'h00;
         mb_oak   = mb_aok ? m_known[address_a] : 1'b1;
         mb_ob    = mb_bok ? m_mem[address_b] : 8'h00;
         mb_obk   = mb_bok ? m_known[address_b] : 1'b1;
         if (!mb_busy) begin
            if (write_a) begin e_a = mb_aok ? in_a : 8'h00; ka = 1; end
            else begin e_a = mb_oa; ka = mb_oak; end
         end
         if (write_b) begin e_b = mb_bok ? in_b : 8'h00; kb = 1; end
         else begin e_b = mb_ob; kb = mb_obk; end
         if (write_b && mb_bok && !(mb_sweep && int'(address_b) == m_pos)
             && !(!mb_busy && write_a && address_a == address_b)) begin
            m_mem[address_b] = in_b; m_known[address_b] = 1;
         end
         if (!mb_busy && write_a && mb_aok) begin
            m_mem[address_a] = in_a; m_known[address_a] = 1;
         end
         if (mb_sweep) begin
            m_mem[m_pos] = m_fill; m_known[m_pos] = 1;
         end
         if (m_pos < 0) begin
            if (clear) begin m_pos = 0; m_fill = fill; end
         end else begin
            m_pos++;
            if (m_pos > DEPTH) m_pos = -1;
         end
      end
   end

   always @(negedge clock) begin
      chk("busy", {31'd0, busy}, {31'd0, m_pos >= 0});
      chk("clear_done", {31'd0, clear_done}, {31'd0, m_pos == DEPTH});
      if (ka) chk("out_a", {24'd0, out_a}, {24'd0, e_a});
      if (kb) chk("out_b", {24'd0, out_b}, {24'd0, e_b});
   end

   // Issue a clear and follow the sweep to completion, counting busy cycles.
   task automatic run_sweep(input logic [7:0] fv, input bit stress);
      int busy_cnt = 0, done_cnt = 0, done_at = -1;
      fill = fv; clear = 1; tick(); clear = 0; fill = 0;
      for (int j = 0; j < 8000; j++) begin
         if (busy) busy_cnt++;
         if (clear_done) begin done_cnt++; done_at = j; end
         if (!busy) break;
         if (stress) begin
            case (j)
               50: begin write_a = 1; address_a = 0; in_a = 8'h55; clear = 1; fill = 8'h33; end
               51: begin write_a = 0; clear = 0; fill = 0; end
               52: chk("hold_out_a", {24'd0, out_a}, 32'h41);
               60: address_b = 7199;
               61: chk("b_read_in_sweep", {24'd0, out_b}, 32'h99);
               200: begin write_b = 1; address_b = 200; in_b = 8'h77; end
               201: begin write_b = 0; chk("b_wr_own_data", {24'd0, out_b}, 32'h77); end
               default: ;
            endcase
         end
         tick();
      end
      chk("busy_cycles", busy_cnt, 7201);
      chk("done_pulses", done_cnt, 1);
      chk("done_at", done_at, 7200);
   endtask

   initial begin
      for (int i = 0; i < DEPTH; i++) m_mem[i] = 8'h00;
      repeat (3) tick();
      chk("rst_out_a", {24'd0, out_a}, 0);
      chk("rst_out_b", {24'd0, out_b}, 0);
      chk("rst_busy", {31'd0, busy}, 0);
      chk("rst_done", {31'd0, clear_done}, 0);
      reset_n = 1;

      write_a = 1; address_a = 5; in_a = 8'h41; tick();
      write_a = 0; address_b = 5; tick();
      chk("a_wr_b_rd", {24'd0, out_b}, 32'h41);

      write_a = 1; write_b = 1; address_a = 10; address_b = 10; in_a = 8'h11; in_b = 8'h22; tick();
      chk("coll_out_a", {24'd0, out_a}, 32'h11);
      chk("coll_out_b", {24'd0, out_b}, 32'h22);
      write_a = 0; write_b = 0; tick();
      chk("coll_rd_a", {24'd0, out_a}, 32'h11);
      chk("coll_rd_b", {24'd0, out_b}, 32'h11);

      write_a = 1; address_a = 3; in_a = 8'h07; tick();
      in_a = 8'h09; tick();
      chk("rdw_new", {24'd0, out_a}, 32'h09);
      write_a = 0;

      write_a1 = 1; address_a1 = 3; in_a1 = 8'h07; tick();
      in_a1 = 8'h09; tick();
      chk("rdw_old", {24'd0, out_a1}, 32'h07);
      write_a1 = 0; tick();
      chk("rdw_old_after", {24'd0, out_a1}, 32'h09);

      write_a = 1; address_a = 7200; in_a = 8'hAA; tick();
      chk("oor_wr_out", {24'd0, out_a}, 0);
      write_a = 0; address_b = 7200; tick();
      chk("oor_rd", {24'd0, out_b}, 0);
      write_b = 1; address_b = 8191; in_b = 8'hBB; tick();
      write_b = 0; tick();
      chk("oor_rd_top", {24'd0, out_b}, 0);

      write_b = 1; address_b = 7199; in_b = 8'h99; tick();
      write_b = 0; tick();
      chk("seed_7199", {24'd0, out_b}, 32'h99);

      address_a = 5; tick();
      run_sweep(8'h20, 1'b1);

      address_a = 0;
      for (int i = 0; i < DEPTH; i++) begin
         address_b = AW'(i); tick();
         chk("fill_20", {24'd0, out_b}, 32'h20);
      end
      chk("a_wr_ignored", {24'd0, out_a}, 32'h20);

      address_b = 5; fill = 8'h5A; clear = 1; tick();
      clear = 0; fill = 0;
      repeat (100) tick();
      chk("busy_pre_rst", {31'd0, busy}, 1);
      #1 reset_n = 0;
      #1;
      chk("arst_busy", {31'd0, busy}, 0);
      chk("arst_done", {31'd0, clear_done}, 0);
      chk("arst_out_a", {24'd0, out_a}, 0);
      chk("arst_out_b", {24'd0, out_b}, 0);
      tick(); tick();
      reset_n = 1;
      run_sweep(8'h3C, 1'b0);

      address_b = 0; tick();    chk("fill_3c_0", {24'd0, out_b}, 32'h3C);
      address_b = 100; tick();  chk("fill_3c_100", {24'd0, out_b}, 32'h3C);
      address_b = 3000; tick(); chk("fill_3c_3000", {24'd0, out_b}, 32'h3C);
      address_a = 7199; tick(); chk("fill_3c_7199", {24'd0, out_a}, 32'h3C);
      chk("dut1_idle", {30'd0, busy1, clear_done1}, 0);
      chk("dut1_out_b", {24'd0, out_b1}, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/vram_dp_clear.md
VRAM_DP_CLEAR -- requirements
Module: vram_dp_clear

Interface
REQ-001 SHALL have parameter DATA_W, default 8: word width in bits.
REQ-002 SHALL have parameter DEPTH, default 7200: number of words.
REQ-003 SHALL have parameter ADDR_W, default 13: address width; DEPTH <= 2**ADDR_W.
REQ-004 SHALL have parameter RDW_MODE, default 0: same-port read-during-write. 0 = new data, 1 = old data.
REQ-005 SHALL have port clock  input  1: single clock; all logic on rising edge.
REQ-006 SHALL have port reset_n  input  1: asynchronous, active-low reset.
REQ-007 SHALL have port address_a  input  ADDR_W: port A word address.
REQ-008 SHALL have port in_a  input  DATA_W: port A write data.
REQ-009 SHALL have port write_a  input  1: port A write strobe.
REQ-010 SHALL have port out_a  output  DATA_W: port A registered read data.
REQ-011 SHALL have port address_b  input  ADDR_W: port B word address.
REQ-012 SHALL have port in_b  input  DATA_W: port B write data.
REQ-013 SHALL have port write_b  input  1: port B write strobe.
REQ-014 SHALL have port out_b  output  DATA_W: port B registered read data.
REQ-015 SHALL have port clear  input  1: single-cycle request to fill the whole memory.
REQ-016 SHALL have port fill  input  DATA_W: fill value, sampled with clear.
REQ-017 SHALL have port busy  output  1: high while a fill sweep is in progress.
REQ-018 SHALL have port clear_done  output  1: one-cycle pulse when a sweep completes.

Function
REQ-019 SHALL give each port a read latency of 1 cycle: out_x updates on the edge after the address is presented.
REQ-020 SHALL, on a port write with RDW_MODE=0, load out_x with in_x in the same cycle; with RDW_MODE=1, load out_x with the prior stored word.
REQ-021 SHALL ignore writes to addresses >= DEPTH; reads of addresses >= DEPTH SHALL return 0.
REQ-022 SHALL, when both ports write the same address in one cycle, store in_a (port A wins). Each port's out_x SHALL follow REQ-020 for its own data.
REQ-023 SHALL, when one port reads an address the other port writes in the same cycle, return the old word.
REQ-024 SHALL implement FSM states IDLE, SWEEP, DONE.
REQ-025 SHALL, in IDLE with clear=1, latch fill into a fill register, zero the sweep counter, and go to SWEEP.
REQ-026 SHALL, in SWEEP, write the fill register to mem[counter] each cycle and increment the counter. After writing DEPTH-1 it SHALL go to DONE, so a sweep takes exactly DEPTH cycles.
REQ-027 SHALL go from DONE to IDLE after one cycle; clear_done=1 only in DONE.
REQ-028 SHALL drive busy=1 in SWEEP and DONE, and 0 in IDLE.
REQ-029 SHALL ignore clear while busy=1; no restart and no fill re-latch.
REQ-030 SHALL, while busy=1, ignore write_a and hold out_a. Port B reads and writes SHALL continue normally.
REQ-031 SHALL, in SWEEP, let the sweep write win when write_b targets the same address as the counter in that cycle.
REQ-032 SHALL keep the counter ADDR_W wide with no wrap past DEPTH-1.

Reset
REQ-033 SHALL, on reset_n=0, immediately force out_a=0, out_b=0, busy=0, clear_done=0, state=IDLE, counter=0 and fill register=0.
REQ-034 SHALL NOT reset memory contents; after reset mid-sweep, contents are unspecified until rewritten.
REQ-035 SHALL accept accesses starting from the first rising edge after reset_n deasserts.

Verification
REQ-036 Bench SHALL cover: write_a 0x41 to addr 5, then read addr 5 on port B -> out_b=0x41 one cycle after the address is presented.
REQ-037 Bench SHALL cover: write_a 0x11 and write_b 0x22 both to addr 10, then read -> 0x11. With RDW_MODE=1 and mem[3]=0x07, write_a 0x09 to addr 3 -> out_a=0x07 that cycle.
REQ-038 Bench SHALL cover: clear with fill=0x20 at default DEPTH -> busy high for 7201 cycles, clear_done pulses once after 7200 sweep cycles, and all 7200 words read 0x20.
REQ-039 Bench SHALL cover: during a sweep, write_a 0x55 to addr 0 -> ignored; second clear with fill=0x33 -> ignored, final contents 0x20; port B read of addr 7199 still returns data.
REQ-040 Bench SHALL cover: reset_n=0 at sweep cycle 100 -> busy=0 and outputs 0 without waiting for a clock edge; a new clear afterwards completes normally.
REQ-041 Bench SHALL cover: write to addr 7200 (DEPTH) -> no effect; read of addr 7200 -> 0.
